// File: rtl/pulse_pattern_checker_pkg.sv
// Shared definitions for the pulse pattern checker and its stimulus generator:
// default geometry, FSM state encoding and saturating-increment helpers.
package pulse_pattern_checker_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_LOSS_LIMIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pulse_pattern_checker_if.sv
// Bus between the pulse generator side (master) and the pattern checker (slave).
interface pulse_pattern_checker_if
  import pulse_pattern_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             serial_in;
  logic [WIDTH-1:0] pattern;
  logic             start;
  logic             locked;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             error;
  logic [7:0]       mismatch_count;
  logic [15:0]      ones_count;

  modport master (
    output serial_in, pattern, start,
    input  locked, word_out, word_valid, error, mismatch_count, ones_count
  );

  modport slave (
    input  serial_in, pattern, start,
    output locked, word_out, word_valid, error, mismatch_count, ones_count
  );

endinterface

// File: rtl/pulse_pattern_checker_serial_deserializer.sv
// MSB-first shift register; shift_next_o is the window including the bit
// arriving this cycle, so the checker can compare before the register updates.
module serial_deserializer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] shift_next_o
);

  logic [WIDTH-1:0] shift_q;

  assign shift_next_o = {shift_q[WIDTH-2:0], serial_i};

  // Shift one bit per clock; a restart flushes stale history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_next_o;
    end
  end

endmodule

// File: rtl/pulse_pattern_checker.sv
// Word-alignment checker for a serial rotating test pattern.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for start; nothing counted
//   ST_HUNT   | sliding window search; compares once WIDTH bits have arrived
//   ST_LOCKED | aligned; checks one word every WIDTH clocks
module pulse_pattern_checker
  import pulse_pattern_checker_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOSS_LIMIT = DEF_LOSS_LIMIT
) (
  input logic                    clock,
  input logic                    reset_n,
  pulse_pattern_checker_if.slave bus
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int BIT_W  = $clog2(WIDTH);
  localparam int MISS_W = $clog2(LOSS_LIMIT + 1);

  state_e             state_q;
  logic [FILL_W-1:0]  fill_q;
  logic [BIT_W-1:0]   bit_q;
  logic [MISS_W-1:0]  miss_q;
  logic [MISS_W-1:0]  miss_d;
  logic               locked_q;
  logic [WIDTH-1:0]   word_out_q;
  logic               word_valid_q;
  logic               error_q;
  logic [7:0]         mismatch_q;
  logic [15:0]        ones_q;

  logic [WIDTH-1:0]   shift_next;
  logic               word_match;
  logic               fill_full;
  logic               word_end;
  logic               loss_hit;

  serial_deserializer #(.WIDTH(WIDTH)) u_deser (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear_i      (bus.start),
    .serial_i     (bus.serial_in),
    .shift_next_o (shift_next)
  );

  assign word_match = (shift_next == bus.pattern);
  // The current bit is the WIDTH-th or later once WIDTH-1 bits are already in.
  assign fill_full  = (fill_q >= FILL_W'(WIDTH - 1));
  assign word_end   = (bit_q == BIT_W'(WIDTH - 1));
  assign miss_d     = miss_q + 1'b1;
  assign loss_hit   = (miss_d == MISS_W'(LOSS_LIMIT));

  // Alignment FSM with all outputs and counters registered; start overrides everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fill_q       <= '0;
      bit_q        <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      error_q      <= 1'b0;
      mismatch_q   <= '0;
      ones_q       <= '0;
    end else begin
      word_valid_q <= 1'b0;
      error_q      <= 1'b0;
      if (bus.start) begin
        state_q    <= ST_HUNT;
        fill_q     <= '0;
        bit_q      <= '0;
        miss_q     <= '0;
        locked_q   <= 1'b0;
        mismatch_q <= '0;
        ones_q     <= '0;
      end else begin
        if (state_q != ST_IDLE && bus.serial_in) begin
          ones_q <= sat_inc16(ones_q);
        end
        case (state_q)
          ST_IDLE: begin
          end
          ST_HUNT: begin
            if (fill_q != FILL_W'(WIDTH)) begin
              fill_q <= fill_q + 1'b1;
            end
            if (fill_full && word_match) begin
              state_q  <= ST_LOCKED;
              bit_q    <= '0;
              miss_q   <= '0;
              locked_q <= 1'b1;
            end
          end
          ST_LOCKED: begin
            bit_q <= word_end ? '0 : bit_q + 1'b1;
            if (word_end) begin
              word_out_q   <= shift_next;
              word_valid_q <= 1'b1;
              if (!word_match) begin
                error_q    <= 1'b1;
                mismatch_q <= sat_inc8(mismatch_q);
                if (loss_hit) begin
                  state_q  <= ST_HUNT;
                  fill_q   <= '0;
                  miss_q   <= '0;
                  locked_q <= 1'b0;
                end else begin
                  miss_q <= miss_d;
                end
              end else begin
                miss_q <= '0;
              end
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked         = locked_q;
  assign bus.word_out       = word_out_q;
  assign bus.word_valid     = word_valid_q;
  assign bus.error          = error_q;
  assign bus.mismatch_count = mismatch_q;
  assign bus.ones_count     = ones_q;

endmodule

// File: tb/tb_pulse_pattern_checker.sv
// Directed bench for pulse_pattern_checker: expected words are queued as they
// are sent and matched against each word_valid strobe.
module tb_pulse_pattern_checker;

  logic clock;
  logic reset_n;

  pulse_pattern_checker_if #(.WIDTH(16)) bus ();

  pulse_pattern_checker #(.WIDTH(16), .LOSS_LIMIT(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  logic [16:0] sb[$];
  logic        active = 1'b0;
  logic [15:0] exp_ones = '0;
  logic [7:0]  exp_mis = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit: drive on falling edge, update the model at the rising edge, sample 1 time unit later.
  task automatic send_bit(input logic b, input logic st);
    logic [16:0] e;
    @(negedge clock);
    bus.serial_in = b;
    bus.start     = st;
    @(posedge clock);
    if (st) begin
      active   = 1'b1;
      exp_ones = '0;
      exp_mis  = '0;
    end else if (active && b && exp_ones != 16'hFFFF) begin
      exp_ones = exp_ones + 16'd1;
    end
    #1;
    chk("ones_count", bus.ones_count, exp_ones);
    if (bus.word_valid === 1'b1) begin
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("word_out", bus.word_out, e[15:0]);
        chk("error", bus.error, e[16]);
      end
    end else begin
      chk("error_without_valid", bus.error, 0);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic expect_out);
    if (expect_out) begin
      sb.push_back({w != bus.pattern, w});
      if (w != bus.pattern && exp_mis != 8'hFF) exp_mis = exp_mis + 8'd1;
    end
    for (int i = 15; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask

  // First aligned word while hunting: locked must stay low until its last bit.
  task automatic hunt_word(input logic [15:0] w, input string tag);
    for (int i = 15; i >= 1; i--) send_bit(w[i], 1'b0);
    chk({tag, "_not_locked_early"}, bus.locked, 0);
    send_bit(w[0], 1'b0);
    chk({tag, "_locked"}, bus.locked, 1);
  endtask

  task automatic do_start(input logic [15:0] pat);
    bus.pattern = pat;
    send_bit(1'b0, 1'b1);
    chk("start_locked", bus.locked, 0);
    chk("start_mismatch", bus.mismatch_count, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    active   = 1'b0;
    exp_ones = '0;
    exp_mis  = '0;
    sb.delete();
    chk("rst_locked", bus.locked, 0);
    chk("rst_word_valid", bus.word_valid, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_word_out", bus.word_out, 0);
    chk("rst_mismatch", bus.mismatch_count, 0);
    chk("rst_ones", bus.ones_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.serial_in = 1'b0;
    bus.start     = 1'b0;
    bus.pattern   = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    chk("por_locked", bus.locked, 0);
    chk("por_word_valid", bus.word_valid, 0);
    chk("por_word_out", bus.word_out, 0);
    chk("por_mismatch", bus.mismatch_count, 0);
    chk("por_ones", bus.ones_count, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Idle without start: matching stream must neither lock nor count.
    bus.pattern = 16'hA5F0;
    send_word(16'hA5F0, 1'b0);
    send_word(16'hA5F0, 1'b0);
    chk("idle_no_lock", bus.locked, 0);

    // Clean A5F0 stream: lock on 16th bit, then one good word every 16 clocks.
    do_start(16'hA5F0);
    hunt_word(16'hA5F0, "a5f0");
    for (int n = 0; n < 4; n++) send_word(16'hA5F0, 1'b1);
    chk("a5f0_drained", sb.size(), 0);
    chk("a5f0_mismatch", bus.mismatch_count, 0);
    chk("a5f0_ones", bus.ones_count, 40);

    // 8001 with a single corrupted word: one error, lock kept.
    do_start(16'h8001);
    hunt_word(16'h8001, "8001");
    send_word(16'h8001, 1'b1);
    send_word(16'h8011, 1'b1);
    send_word(16'h8001, 1'b1);
    chk("single_err_mismatch", bus.mismatch_count, exp_mis);
    chk("single_err_mismatch_is_1", bus.mismatch_count, 1);
    chk("single_err_locked", bus.locked, 1);

    // Two consecutive bad words drop lock; the next clean word relocks.
    send_word(16'h0001, 1'b1);
    chk("loss_first_bad_locked", bus.locked, 1);
    send_word(16'h8000, 1'b1);
    chk("loss_unlocked", bus.locked, 0);
    chk("loss_mismatch", bus.mismatch_count, 3);
    hunt_word(16'h8001, "relock");
    send_word(16'h8001, 1'b1);
    chk("relock_drained", sb.size(), 0);

    // All-zero pattern.
    do_start(16'h0000);
    hunt_word(16'h0000, "zeros");
    send_word(16'h0000, 1'b1);
    chk("zeros_ones", bus.ones_count, 0);

    // All-one pattern: ones_count tracks every clock.
    do_start(16'hFFFF);
    hunt_word(16'hFFFF, "ones");
    chk("ones_after_lock", bus.ones_count, 16);
    send_word(16'hFFFF, 1'b1);

    // Start on a word boundary: no strobe for that word.
    for (int i = 0; i < 15; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("bnd_start_locked", bus.locked, 0);
    chk("bnd_start_mismatch", bus.mismatch_count, 0);
    hunt_word(16'hFFFF, "bnd_relock");
    send_word(16'hFFFF, 1'b1);

    // Reset mid-word, then stay idle until the next start.
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    pulse_reset();
    for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
    chk("post_rst_idle_locked", bus.locked, 0);
    chk("post_rst_word_out", bus.word_out, 0);

    // Mismatch counter saturation: 300 bad words alternating with good ones.
    do_start(16'h1234);
    hunt_word(16'h1234, "sat");
    for (int n = 0; n < 300; n++) begin
      send_word(16'h1334, 1'b1);
      send_word(16'h1234, 1'b1);
    end
    chk("sat_mismatch_model", bus.mismatch_count, exp_mis);
    chk("sat_mismatch_255", bus.mismatch_count, 255);
    chk("sat_locked", bus.locked, 1);
    chk("final_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
